// File: rtl/adder_pkg.sv
// Shared widths, node addresses and state encoding for the adder endpoint.
package adder_pkg;

  // AXI-Stream field widths used by the NoC
  localparam int AXIS_MAX_DATAW = 64;
  localparam int DATAW          = 64;
  localparam int AXIS_DESTW     = 4;
  localparam int AXIS_USERW     = 4;
  localparam int AXIS_IDW       = 4;
  localparam int AXIS_STRBW     = 8;
  localparam int AXIS_KEEPW     = 8;

  // Node address of the adder on the NoC
  localparam logic [AXIS_DESTW-1:0] DEST_ADDR = 4'd5;

  // Adder defaults
  localparam int ADDER_ACCW = 64;
  localparam int ADDER_CNTW = 16;

  // ACCUM accepts beats, HOLD presents a finished result
  typedef enum logic {
    ADDER_ST_ACCUM = 1'b0,
    ADDER_ST_HOLD  = 1'b1
  } adder_state_e;

endpackage

// File: rtl/adder_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // Count up on inc until saturated; rst or clr return to zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/adder.sv
// NoC endpoint: sums addressed AXI-Stream beats per packet and presents
// the total, beat count, overflow flag and source on a valid/ready port.
module adder
  import adder_pkg::*;
#(
  parameter int                     ACCW    = ADDER_ACCW,  // must not exceed DATAW
  parameter logic [AXIS_DESTW-1:0]  MY_ADDR = DEST_ADDR,
  parameter int                     CNTW    = ADDER_CNTW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axis_adder_interface_tvalid,
  output logic                      axis_adder_interface_tready,
  input  logic                      axis_adder_interface_tlast,
  input  logic [AXIS_MAX_DATAW-1:0] axis_adder_interface_tdata,
  input  logic [AXIS_DESTW-1:0]     axis_adder_interface_tdest,
  input  logic [AXIS_USERW-1:0]     axis_adder_interface_tuser,
  input  logic [AXIS_IDW-1:0]       axis_adder_interface_tid,
  input  logic [AXIS_STRBW-1:0]     axis_adder_interface_tstrb,
  input  logic [AXIS_KEEPW-1:0]     axis_adder_interface_tkeep,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [ACCW-1:0]           result_sum,
  output logic [AXIS_USERW-1:0]     result_src,
  output logic [CNTW-1:0]           result_beats,
  output logic                      result_overflow,
  output logic [CNTW-1:0]           drop_count
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  adder_state_e            r_state;
  logic [ACCW-1:0]         r_sum;
  logic                    r_ovf;
  logic [ACCW-1:0]         r_res_sum;
  logic [AXIS_USERW-1:0]   r_res_src;
  logic [CNTW-1:0]         r_res_beats;
  logic                    r_res_ovf;

  logic                    w_accept;
  logic                    w_hit;
  logic                    w_miss;
  logic                    w_close;
  logic [ACCW:0]           w_add;
  logic [CNTW-1:0]         w_beats;
  logic [CNTW-1:0]         w_beats_sat;
  logic [CNTW-1:0]         w_drops;
  logic                    w_unused;

  // tid/tstrb/tkeep carry no meaning for this node
  assign w_unused = ^{axis_adder_interface_tid, axis_adder_interface_tstrb,
                      axis_adder_interface_tkeep};

  // Beat classification and the carry-extended running addition
  always_comb begin
    w_accept    = axis_adder_interface_tvalid && (r_state == ADDER_ST_ACCUM);
    w_hit       = w_accept && (axis_adder_interface_tdest == MY_ADDR);
    w_miss      = w_accept && (axis_adder_interface_tdest != MY_ADDR);
    w_close     = w_hit && axis_adder_interface_tlast;
    w_add       = {1'b0, r_sum} + {1'b0, axis_adder_interface_tdata[ACCW-1:0]};
    w_beats_sat = (&w_beats) ? w_beats : (w_beats + CNT_ONE);
  end

  // Beats of the packet in progress; cleared as the packet closes
  sat_counter #(.W(CNTW)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_close),
    .inc   (w_hit),
    .count (w_beats)
  );

  // Misaddressed beats since reset
  sat_counter #(.W(CNTW)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (w_miss),
    .count (w_drops)
  );

  // State, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ADDER_ST_ACCUM;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_res_sum   <= '0;
      r_res_src   <= '0;
      r_res_beats <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ADDER_ST_ACCUM: begin
          if (w_close) begin
            r_res_sum   <= w_add[ACCW-1:0];
            r_res_ovf   <= r_ovf | w_add[ACCW];
            r_res_beats <= w_beats_sat;
            r_res_src   <= axis_adder_interface_tuser;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_state     <= ADDER_ST_HOLD;
          end else if (w_hit) begin
            r_sum <= w_add[ACCW-1:0];
            r_ovf <= r_ovf | w_add[ACCW];
          end
        end
        ADDER_ST_HOLD: begin
          if (result_ready) begin
            r_state <= ADDER_ST_ACCUM;
          end
        end
        default: r_state <= ADDER_ST_ACCUM;
      endcase
    end
  end

  assign axis_adder_interface_tready = (r_state == ADDER_ST_ACCUM);
  assign result_valid                = (r_state == ADDER_ST_HOLD);
  assign result_sum                  = r_res_sum;
  assign result_src                  = r_res_src;
  assign result_beats                = r_res_beats;
  assign result_overflow             = r_res_ovf;
  assign drop_count                  = w_drops;

endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: a cycle-level behavioural model checked every
// cycle plus hand-computed expectations for each packet.
module tb_adder;
  import adder_pkg::*;

  localparam logic [3:0] MY    = DEST_ADDR;
  localparam logic [3:0] OTHER = 4'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [63:0] tdata;
  logic [3:0]  tdest;
  logic [3:0]  tuser;
  logic [3:0]  tid;
  logic [7:0]  tstrb;
  logic [7:0]  tkeep;
  logic        result_valid;
  logic        result_ready;
  logic [63:0] result_sum;
  logic [3:0]  result_src;
  logic [15:0] result_beats;
  logic        result_overflow;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  adder dut (
    .clk                         (clk),
    .rst                         (rst),
    .axis_adder_interface_tvalid (tvalid),
    .axis_adder_interface_tready (tready),
    .axis_adder_interface_tlast  (tlast),
    .axis_adder_interface_tdata  (tdata),
    .axis_adder_interface_tdest  (tdest),
    .axis_adder_interface_tuser  (tuser),
    .axis_adder_interface_tid    (tid),
    .axis_adder_interface_tstrb  (tstrb),
    .axis_adder_interface_tkeep  (tkeep),
    .result_valid                (result_valid),
    .result_ready                (result_ready),
    .result_sum                  (result_sum),
    .result_src                  (result_src),
    .result_beats                (result_beats),
    .result_overflow             (result_overflow),
    .drop_count                  (drop_count)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: packet totals kept as plain arithmetic, counts as
  // unbounded integers clipped to the counter range when compared.
  bit          m_hold;
  logic [63:0] m_sum;
  bit          m_ovf;
  int          m_n;
  int          m_drops;
  logic [63:0] m_res_sum;
  logic [3:0]  m_res_src;
  int          m_res_n;
  bit          m_res_ovf;

  function automatic logic [15:0] clip(input int n);
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  // Compare DUT to model, then advance the model by what the next edge does
  always @(negedge clk) begin
    logic [64:0] t;
    if (chk_en) begin
      check("m_tready",    {63'd0, tready},          {63'd0, !m_hold});
      check("m_valid",     {63'd0, result_valid},    {63'd0, m_hold});
      check("m_sum",       result_sum,               m_res_sum);
      check("m_src",       {60'd0, result_src},      {60'd0, m_res_src});
      check("m_beats",     {48'd0, result_beats},    {48'd0, clip(m_res_n)});
      check("m_ovf",       {63'd0, result_overflow}, {63'd0, m_res_ovf});
      check("m_drops",     {48'd0, drop_count},      {48'd0, clip(m_drops)});
    end
    if (rst) begin
      m_hold = 0; m_sum = 0; m_ovf = 0; m_n = 0; m_drops = 0;
      m_res_sum = 0; m_res_src = 0; m_res_n = 0; m_res_ovf = 0;
    end else if (!m_hold) begin
      if (tvalid) begin
        if (tdest == MY) begin
          t = {1'b0, m_sum} + {1'b0, tdata};
          if (t > 65'h0_FFFF_FFFF_FFFF_FFFF) m_ovf = 1;
          m_sum = t[63:0];
          m_n++;
          if (tlast) begin
            m_res_sum = m_sum; m_res_src = tuser; m_res_n = m_n; m_res_ovf = m_ovf;
            m_sum = 0; m_ovf = 0; m_n = 0; m_hold = 1;
          end
        end else begin
          m_drops++;
        end
      end
    end else if (result_ready) begin
      m_hold = 0;
    end
  end

  // Present one beat and wait until it is accepted; waited = edges consumed
  task automatic beat(input logic [63:0] d, input logic [3:0] dst, input logic last,
                      input logic [3:0] usr, output int waited);
    bit acc;
    tvalid = 1; tdata = d; tdest = dst; tlast = last; tuser = usr;
    waited = 0; acc = 0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    tvalid = 0; tlast = 0; tdata = 0; tdest = 0; tuser = 0;
  endtask

  task automatic expect_result(input string nm, input logic [63:0] s, input logic [15:0] n,
                               input logic ovf, input logic [3:0] src);
    check({nm, "_valid"}, {63'd0, result_valid},    64'd1);
    check({nm, "_sum"},   result_sum,               s);
    check({nm, "_beats"}, {48'd0, result_beats},    {48'd0, n});
    check({nm, "_ovf"},   {63'd0, result_overflow}, {63'd0, ovf});
    check({nm, "_src"},   {60'd0, result_src},      {60'd0, src});
    $display("result %s sum=%0d beats=%0d ovf=%0d src=%0d drops=%0d",
             nm, result_sum, result_beats, result_overflow, result_src, drop_count);
  endtask

  initial begin
    int w;
    rst = 1; tid = 0; tstrb = 0; tkeep = 0; result_ready = 1;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    check("rst_tready", {63'd0, tready},       64'd1);
    check("rst_valid",  {63'd0, result_valid}, 64'd0);
    check("rst_sum",    result_sum,            64'd0);
    check("rst_drops",  {48'd0, drop_count},   64'd0);

    // Sum check: 5 + 7 + 30
    beat(64'd5,  MY, 0, 4'd3, w);
    beat(64'd7,  MY, 0, 4'd3, w);
    beat(64'd30, MY, 1, 4'd3, w);
    idle();
    expect_result("sum", 64'd42, 16'd3, 1'b0, 4'd3);
    check("sum_tready_low", {63'd0, tready}, 64'd0);
    @(posedge clk); #1;
    check("sum_valid_1cyc",  {63'd0, result_valid}, 64'd0);
    check("sum_tready_back", {63'd0, tready},       64'd1);

    // Backpressure: hold for 10 cycles with the next beat waiting
    result_ready = 0;
    beat(64'd100, MY, 1, 4'd1, w);
    tvalid = 1; tdata = 64'd200; tdest = MY; tlast = 1; tuser = 4'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_tready", {63'd0, tready}, 64'd0);
      check("bp_sum",    result_sum,      64'd100);
    end
    expect_result("bp_held", 64'd100, 16'd1, 1'b0, 4'd1);
    result_ready = 1;
    beat(64'd200, MY, 1, 4'd2, w);
    check("bp_accept_edge", w, 64'd2);
    expect_result("bp_next", 64'd200, 16'd1, 1'b0, 4'd2);

    // Overflow then a clean packet
    beat(64'hFFFF_FFFF_FFFF_FFFF, MY, 0, 4'd4, w);
    beat(64'd2, MY, 1, 4'd4, w);
    expect_result("ovf", 64'd1, 16'd2, 1'b1, 4'd4);
    beat(64'd4, MY, 1, 4'd4, w);
    expect_result("ovf_clear", 64'd4, 16'd1, 1'b0, 4'd4);

    // Misaddressed beat with tlast does not close the packet
    beat(64'd10, MY,    0, 4'd6, w);
    beat(64'd99, OTHER, 1, 4'd6, w);
    check("mis_no_result", {63'd0, result_valid}, 64'd0);
    beat(64'd20, MY,    1, 4'd6, w);
    expect_result("mis", 64'd30, 16'd2, 1'b0, 4'd6);
    check("mis_drops", {48'd0, drop_count}, 64'd1);

    // Reset mid-packet discards partial sum and drop count
    beat(64'd8, MY, 0, 4'd7, w);
    beat(64'd9, MY, 0, 4'd7, w);
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst_mid_drops", {48'd0, drop_count}, 64'd0);
    beat(64'd1, MY, 1, 4'd7, w);
    expect_result("rst_mid", 64'd1, 16'd1, 1'b0, 4'd7);
    check("rst_mid_drops2", {48'd0, drop_count}, 64'd0);

    // Single zero beat
    beat(64'd0, MY, 1, 4'd8, w);
    expect_result("single0", 64'd0, 16'd1, 1'b0, 4'd8);

    // Beat count saturation: 65541 beats of 1
    for (int i = 0; i < 65540; i++) beat(64'd1, MY, 0, 4'd9, w);
    beat(64'd1, MY, 1, 4'd9, w);
    expect_result("sat", 64'd65541, 16'hFFFF, 1'b0, 4'd9);

    idle();
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder.md
# adder

Downstream endpoint of the client → NoC → adder path. Receives AXI-Stream beats addressed to the adder node and accumulates the low `ACCW` bits of each beat's tdata into a running sum. When a beat arrives with tlast, the block presents the completed sum, the beat count and the source address on a valid/ready result port. It holds the NoC input in backpressure until that result is consumed.

## Interface
Parameters:
- `ACCW`, default 64: accumulator and result width. The operand is tdata[ACCW-1:0], and `ACCW` must be ≤ `` `DATAW ``.
- `MY_ADDR`, default `` `DEST_ADDR ``: node address. Only beats whose tdest equals this value are summed.
- `CNTW`, default 16: width of the beat and drop counters.

Ports:
- `clk`  in  1  clock. Reset `rst` is synchronous, active-high; clock is `clk`.
- `rst`  in  1  synchronous active-high reset.
- `axis_adder_interface_tvalid`  in  1  NoC beat valid.
- `axis_adder_interface_tready`  out  1  beat accept.
- `axis_adder_interface_tlast`  in  1  final beat of packet.
- `axis_adder_interface_tdata`  in  `` `AXIS_MAX_DATAW ``  payload.
- `axis_adder_interface_tdest`  in  `` `AXIS_DESTW ``  destination node.
- `axis_adder_interface_tuser`  in  `` `AXIS_USERW ``  source node address.
- `axis_adder_interface_tid`, `_tstrb`, `_tkeep`  in  `` `AXIS_IDW ``/`` `AXIS_STRBW ``/`` `AXIS_KEEPW ``  ignored.
- `result_valid`  out  1  result held.
- `result_ready`  in  1  result consumer ready.
- `result_sum`  out  `ACCW`  completed sum.
- `result_src`  out  `` `AXIS_USERW ``  tuser captured from the tlast beat.
- `result_beats`  out  `CNTW`  summed beats in the packet, tlast beat included; saturating.
- `result_overflow`  out  1  unsigned carry-out occurred at least once during the packet.
- `drop_count`  out  `CNTW`  misaddressed beats since reset; saturating.

## Operation
- Two states:
  - ACCUM: tready=1.
  - HOLD: tready=0 and result_valid=1.
- Accept = tvalid && tready.
- Accepted beat with tdest==`MY_ADDR`:
  - sum ← sum + tdata[ACCW-1:0], modulo 2^ACCW.
  - Carry-out sets the sticky ovf bit.
  - beats ← beats+1, saturating at 2^CNTW-1.
- If that beat also has tlast:
  - result_sum, result_beats and result_overflow load the updated values, including this beat.
  - result_src ← tuser.
  - Internal sum, beats and ovf clear.
  - State → HOLD.
- Accepted beat with tdest≠`MY_ADDR`:
  - Consumed without being summed.
  - drop_count+1, saturating.
  - tlast on this beat is ignored and does not close the packet.
- HOLD → ACCUM on result_valid && result_ready.
- Result outputs are stable throughout HOLD.
- Data-driven stimulus has a defined response everywhere. Zero-valued beats count toward result_beats. A single-beat packet yields beats=1.

## Timing
- Reset values:
  - state = ACCUM, so tready=1 in the first cycle after reset.
  - result_valid = 0.
  - result_sum, result_src, result_beats, result_overflow = 0.
  - drop_count = 0.
  - Internal sum, beats and ovf = 0.
- Latency: a tlast beat accepted at edge N gives result_valid=1 from edge N+1.
- tready is registered state decode. It drops to 0 in the cycle after the tlast accept, so no beat is accepted while HOLD is entered.
- Result handshake at edge M: result_valid=0 and tready=1 from edge M+1. There is no same-cycle bypass.
- Back-to-back packets: minimum packet-to-packet spacing is tlast accept + 1 HOLD cycle when result_ready is tied high.
- Reset mid-packet or in HOLD: the partial sum and held result are discarded and all registers return to their reset values at the next edge.
- `ACCW` addition uses an `ACCW`+1-bit intermediate. Bit `ACCW` is the carry.

## Structure
- Add to `static_params.vh`:
  - `` `ADDER_ACCW `` (64).
  - `` `ADDER_CNTW `` (16).
  - State encodings `` `ADDER_ST_ACCUM ``=1'b0 and `` `ADDER_ST_HOLD ``=1'b1.
- One sub-module: `sat_counter` (parameter W; ports clk, rst, clr, inc, count). Instantiate it for the beat count and for drop_count.
- Single always block for state and datapath. Outputs are driven from registers only.

## Test plan
- Sum check: beats 5, 7, 30 (tlast on 30), tdest=`MY_ADDR`, tuser=3, result_ready=1. Expect result_sum=42, beats=3, src=3, overflow=0, result_valid high for exactly 1 cycle, tready=0 for exactly 1 cycle.
- Backpressure: result_ready=0 for 10 cycles after a tlast beat while tvalid stays 1. Expect tready=0 and the result stable for all 10 cycles, with no beat accepted. The next packet's first beat is accepted the cycle after the handshake.
- Overflow: beats 2^64-1 then 2 (tlast). Expect result_sum=1, result_overflow=1. The following packet 4 (tlast) gives sum=4, overflow=0.
- Misaddressed beat: beats 10, 99 with tdest≠`MY_ADDR` and tlast, then 20 (tlast). Expect drop_count=1 and a single result with sum=30, beats=2.
- Reset mid-operation: assert rst after beats 8 and 9 with no tlast, then send 1 (tlast). Expect result_sum=1, beats=1, drop_count=0.
- Single-beat and saturation: one beat 0 (tlast) gives sum=0, beats=1. Sending 2^16+5 beats gives result_beats=65535.
